// File: rtl/axi4_rand_mem_if.sv
// AXI4-Lite bus bundle between the CPU-side adapter (master) and the randomised memory model (slave).
interface axi4_rand_mem_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              s_awvalid;
  logic              s_awready;
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_wvalid;
  logic              s_wready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_bvalid;
  logic              s_bready;
  logic              s_arvalid;
  logic              s_arready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_rvalid;
  logic              s_rready;
  logic [31:0]       s_rdata;

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata
  );

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata
  );
endinterface

// File: rtl/axi4_rand_mem.sv
// AXI4-Lite slave memory with randomised ready throttling and response latency.
// Optional AXI_RAND_STATS_EN adds rd_count/wr_count handshake counters.
module axi4_rand_mem #(
  parameter int unsigned MEM_WORDS = 16384,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic        clk,
  input  logic        resetn,
`ifdef AXI_RAND_STATS_EN
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
`endif
  input  logic [2:0]  fast_axi_transaction,
  input  logic [4:0]  async_axi_transaction,
  input  logic [4:0]  delay_axi_transaction,
  axi4_rand_mem_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {W_IDLE, W_DLY, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_DLY, R_RESP} rd_state_t;

  logic [31:0]      mem [MEM_WORDS];

  wr_state_t        wr_state;
  rd_state_t        rd_state;
  logic             aw_full;
  logic             w_full;
  logic [IDX_W-1:0] aw_idx;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [CNT_W-1:0] wcnt;
  logic             bvalid_q;
  logic [IDX_W-1:0] ar_idx;
  logic [CNT_W-1:0] rcnt;
  logic             rvalid_q;
  logic [31:0]      rdata_q;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs, wr_commit;

  // Control inputs come from registers upstream, so feeding readies directly is loop-free.
  assign bus.s_awready = !aw_full && (async_axi_transaction[0] || fast_axi_transaction[0]);
  assign bus.s_wready  = !w_full  && (async_axi_transaction[1] || fast_axi_transaction[0]);
  assign bus.s_arready = (rd_state == R_IDLE) &&
                         (async_axi_transaction[2] || fast_axi_transaction[0]);
  assign bus.s_bvalid  = bvalid_q;
  assign bus.s_rvalid  = rvalid_q;
  assign bus.s_rdata   = rdata_q;

  assign aw_hs     = bus.s_awvalid && bus.s_awready;
  assign w_hs      = bus.s_wvalid  && bus.s_wready;
  assign ar_hs     = bus.s_arvalid && bus.s_arready;
  assign b_hs      = bvalid_q && bus.s_bready;
  assign r_hs      = rvalid_q && bus.s_rready;
  assign wr_commit = resetn && (wr_state == W_DLY) && (wcnt == '0);

  // Write path: collect AW and W in any order, wait out the delay, then respond.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_state <= W_IDLE;
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_idx   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wcnt     <= '0;
      bvalid_q <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_full <= 1'b1;
            aw_idx  <= bus.s_awaddr[IDX_W+1:2];
          end
          if (w_hs) begin
            w_full  <= 1'b1;
            wdata_q <= bus.s_wdata;
            wstrb_q <= bus.s_wstrb;
          end
          if ((aw_full || aw_hs) && (w_full || w_hs)) begin
            wcnt     <= fast_axi_transaction[2] ? CNT_W'(0) : delay_axi_transaction;
            wr_state <= W_DLY;
          end
        end
        W_DLY: begin
          if (wcnt != '0) begin
            wcnt <= wcnt - CNT_W'(1);
          end else begin
            bvalid_q <= 1'b1;
            wr_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (bus.s_bready) begin
            bvalid_q <= 1'b0;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Storage is deliberately left unreset; byte lanes follow the latched strobe.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[aw_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  // Read path: a same-edge capture sees the word before any concurrent commit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state <= R_IDLE;
      ar_idx   <= '0;
      rcnt     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            ar_idx   <= bus.s_araddr[IDX_W+1:2];
            rcnt     <= fast_axi_transaction[1] ? CNT_W'(0) : delay_axi_transaction;
            rd_state <= R_DLY;
          end
        end
        R_DLY: begin
          if (rcnt != '0) begin
            rcnt <= rcnt - CNT_W'(1);
          end else begin
            rdata_q  <= mem[ar_idx];
            rvalid_q <= 1'b1;
            rd_state <= R_RESP;
          end
        end
        R_RESP: begin
          if (bus.s_rready) begin
            rvalid_q <= 1'b0;
            rd_state <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

`ifdef AXI_RAND_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (r_hs) rd_count <= rd_count + 32'd1;
      if (b_hs) wr_count <= wr_count + 32'd1;
    end
  end
`else
  logic unused_hs;
  assign unused_hs = r_hs ^ b_hs;
`endif

  // Reserved control bits and address bits outside the word index are ignored.
  logic unused_bits;
  assign unused_bits = ^{async_axi_transaction[4:3], bus.s_awaddr, bus.s_araddr};

endmodule
